// File: rtl/counter_tb_pkg.sv
// counter_tb_pkg: checker state encoding and default widths
package counter_tb_pkg;
  typedef enum logic [1:0] {IDLE, ARM, CHECK, FAILED} state_t;
  localparam int CNT_W = 4;
  localparam int ERR_W_DEF = 8;
endpackage

// File: rtl/count_checker_sat_counter.sv
// sat_counter: event tally that holds at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/count_checker.sv
// count_checker: cycle-accurate reference model of the enable counter with error capture
module count_checker
  import counter_tb_pkg::*;
#(
  parameter int WIDTH       = CNT_W,
  parameter int ERR_W       = ERR_W_DEF,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             check_en,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  output logic             checking,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap_pulse,
  output logic [WIDTH-1:0] exp_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got
);
  state_t state, state_nxt;
  logic cmp, bad;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (check_en ? ARM : IDLE) :
                state == ARM   ? CHECK :
                state == CHECK ? ((bad && STOP_ON_ERR) ? FAILED : (check_en ? CHECK : IDLE)) :
                                 FAILED;
  // X/Z on count must register as a mismatch, hence the case inequality
  always_comb begin
    checking = state == CHECK;
    cmp      = state == CHECK;
    bad      = cmp && (count !== exp_count);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      wrap_pulse <= 1'b0;
      exp_count  <= '0;
      first_exp  <= '0;
      first_got  <= '0;
    end else begin
      mismatch   <= bad;
      wrap_pulse <= cmp && enable && (&exp_count);
      if (state == ARM) exp_count <= count + WIDTH'(enable);
      else if (cmp) exp_count <= exp_count + WIDTH'(enable);
      if (bad) err_sticky <= 1'b1;
      if (bad && !err_sticky) begin
        first_exp <= exp_count;
        first_got <= count;
      end
    end
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk), .reset(reset), .inc(bad), .clr(1'b0), .q(err_count)
  );
endmodule
